// File: rtl/sr_latch_ctrl_pkg.sv
// Shared definitions for the SR latch sequencer: state encoding and arbitration priority.
package sr_latch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PULSE_S = 3'd2,
    ST_PULSE_R = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  localparam logic PRIO_SET = 1'b0;
  localparam logic PRIO_CLR = 1'b1;

endpackage

// File: rtl/sr_latch_ctrl_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module pulse_timer #(
  parameter int unsigned     CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = value;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= RST_VAL;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sole driver of one SR latch: arbitrates set/clear requests, issues timed S/R pulses,
// and checks latch Q against a shadow bit after each recovery gap.
module sr_latch_ctrl
  import sr_latch_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic latch_q,
  output logic latch_s,
  output logic latch_r,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic q_expected,
  output logic mismatch
);

  // A state is left on the edge where the timer reads zero, so loads are one short of
  // the visible cycle count. INIT starts from reset with the full count because the
  // reset cycle itself shows S=R=0.
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LD    = CNT_W'(PULSE_CYCLES);

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   latch_s_q, latch_s_d;
  logic   latch_r_q, latch_r_d;
  logic   set_ack_q, set_ack_d;
  logic   clr_ack_q, clr_ack_d;
  logic   busy_q, busy_d;
  logic   q_exp_q, q_exp_d;
  logic   mismatch_q, mismatch_d;
  logic   grant_s, grant_r;
  logic   tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic   tmr_done;

  pulse_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (INIT_LD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    q_exp_d    = q_exp_q;
    mismatch_d = mismatch_q;
    set_ack_d  = 1'b0;
    clr_ack_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = GAP_LD;
    grant_s    = 1'b0;
    grant_r    = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (tmr_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_IDLE: begin
        grant_s = set_req && (!clr_req || (prio_q == PRIO_SET));
        grant_r = clr_req && (!set_req || (prio_q == PRIO_CLR));
        // Priority only rotates on a true conflict.
        if (set_req && clr_req)
          prio_d = ~prio_q;
        if (grant_s) begin
          state_d   = ST_PULSE_S;
          set_ack_d = 1'b1;
          q_exp_d   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LD;
        end else if (grant_r) begin
          state_d   = ST_PULSE_R;
          clr_ack_d = 1'b1;
          q_exp_d   = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LD;
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        if (tmr_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          if (latch_q != q_exp_q)
            mismatch_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_INIT;
        tmr_load = 1'b1;
        tmr_val  = INIT_LD;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the registered state.
    latch_s_d = (state_d == ST_PULSE_S);
    latch_r_d = (state_d == ST_PULSE_R) || (state_d == ST_INIT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      prio_q     <= PRIO_SET;
      latch_s_q  <= 1'b0;
      latch_r_q  <= 1'b0;
      set_ack_q  <= 1'b0;
      clr_ack_q  <= 1'b0;
      busy_q     <= 1'b1;
      q_exp_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      latch_s_q  <= latch_s_d;
      latch_r_q  <= latch_r_d;
      set_ack_q  <= set_ack_d;
      clr_ack_q  <= clr_ack_d;
      busy_q     <= busy_d;
      q_exp_q    <= q_exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign latch_s    = latch_s_q;
  assign latch_r    = latch_r_q;
  assign set_ack    = set_ack_q;
  assign clr_ack    = clr_ack_q;
  assign busy       = busy_q;
  assign q_expected = q_exp_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl driving a behavioural SR latch; expected vectors are hand-derived.
module tb_sr_latch_ctrl;

  logic clk = 1'b0;
  logic rst, set_req, clr_req, latch_q;
  logic latch_s, latch_r, set_ack, clr_ack, busy, q_expected, mismatch;
  logic lat_q = 1'b0;
  logic force_zero = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;

  always #5 clk = ~clk;

  always @(latch_s or latch_r) begin
    if (latch_s)      lat_q = 1'b1;
    else if (latch_r) lat_q = 1'b0;
  end
  assign latch_q = force_zero ? 1'b0 : lat_q;

  always @(negedge clk) begin
    if ((latch_s && latch_r) || (set_ack && clr_ack)) viol++;
  end

  sr_latch_ctrl #(.PULSE_CYCLES(2), .GAP_CYCLES(1), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_req    (set_req),
    .clr_req    (clr_req),
    .latch_q    (latch_q),
    .latch_s    (latch_s),
    .latch_r    (latch_r),
    .set_ack    (set_ack),
    .clr_ack    (clr_ack),
    .busy       (busy),
    .q_expected (q_expected),
    .mismatch   (mismatch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector order: s r _ set_ack clr_ack _ busy q_expected mismatch
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {latch_s, latch_r, set_ack, clr_ack, busy, q_expected, mismatch};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic exp);
    total++;
    assert (latch_q === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, latch_q, exp);
    end
  endtask

  initial begin
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;
    tick(); tick(); tick();
    chk("reset", 7'b00_00_100);
    rst = 1'b0;

    tick(); chk("init_r1", 7'b01_00_100);
    tick(); chk("init_r2", 7'b01_00_100);
    tick(); chk("init_gap", 7'b00_00_100);
    tick(); chk("init_idle", 7'b00_00_000);
    chk_q("init_latch", 1'b0);

    set_req = 1'b1;
    tick(); chk("set_ack", 7'b10_10_110);
    set_req = 1'b0;
    tick(); chk("set_s2", 7'b10_00_110);
    tick(); chk("set_gap", 7'b00_00_110);
    tick(); chk("set_idle", 7'b00_00_010);
    chk_q("set_latch", 1'b1);

    set_req = 1'b1; clr_req = 1'b1;
    tick(); chk("cf1_set_ack", 7'b10_10_110);
    set_req = 1'b0;
    tick(); chk("cf1_s2", 7'b10_00_110);
    tick(); chk("cf1_gap", 7'b00_00_110);
    tick(); chk("cf1_idle", 7'b00_00_010);
    tick(); chk("cf1_clr_ack", 7'b01_01_100);
    clr_req = 1'b0;
    tick(); chk("cf1_r2", 7'b01_00_100);
    tick(); chk("cf1_gap2", 7'b00_00_100);
    tick(); chk("cf1_idle2", 7'b00_00_000);

    set_req = 1'b1; clr_req = 1'b1;
    tick(); chk("cf2_clr_ack", 7'b01_01_100);
    clr_req = 1'b0;
    tick(); chk("cf2_r2", 7'b01_00_100);
    tick(); chk("cf2_gap", 7'b00_00_100);
    tick(); chk("cf2_idle", 7'b00_00_000);
    tick(); chk("cf2_set_ack", 7'b10_10_110);
    set_req = 1'b0;
    tick(); chk("cf2_s2", 7'b10_00_110);
    tick(); chk("cf2_gap2", 7'b00_00_110);
    tick(); chk("cf2_idle2", 7'b00_00_010);
    chk_q("cf2_latch", 1'b1);

    force_zero = 1'b1;
    set_req = 1'b1;
    tick(); chk("mm_set_ack", 7'b10_10_110);
    set_req = 1'b0;
    tick(); chk("mm_s2", 7'b10_00_110);
    tick(); chk("mm_gap", 7'b00_00_110);
    tick(); chk("mm_flag", 7'b00_00_011);
    force_zero = 1'b0;
    clr_req = 1'b1;
    tick(); chk("mm_clr_ack", 7'b01_01_101);
    clr_req = 1'b0;
    tick(); chk("mm_r2", 7'b01_00_101);
    tick(); chk("mm_gap2", 7'b00_00_101);
    tick(); chk("mm_sticky", 7'b00_00_001);
    chk_q("mm_latch", 1'b0);

    set_req = 1'b1;
    tick(); chk("rs_set_ack", 7'b10_10_111);
    set_req = 1'b0;
    tick(); chk("rs_s2", 7'b10_00_111);
    rst = 1'b1;
    tick(); chk("rs_reset", 7'b00_00_100);
    rst = 1'b0;
    tick(); chk("rs_init_r1", 7'b01_00_100);
    tick(); chk("rs_init_r2", 7'b01_00_100);
    tick(); chk("rs_gap", 7'b00_00_100);
    tick(); chk("rs_idle", 7'b00_00_000);
    chk_q("rs_latch", 1'b0);

    set_req = 1'b1;
    tick(); chk("bz_set_ack", 7'b10_10_110);
    set_req = 1'b0; clr_req = 1'b1;
    tick(); chk("bz_s2", 7'b10_00_110);
    tick(); chk("bz_gap", 7'b00_00_110);
    tick(); chk("bz_idle", 7'b00_00_010);
    tick(); chk("bz_clr_ack", 7'b01_01_100);
    tick(); chk("bz_r2_held", 7'b01_00_100);
    clr_req = 1'b0;
    tick(); chk("bz_gap2", 7'b00_00_100);
    tick(); chk("bz_idle2", 7'b00_00_000);
    tick(); chk("bz_no_reack", 7'b00_00_000);

    total++;
    assert (viol === 0) else begin
      bad++;
      $error("FAIL invariant observed=%0d expected=0", viol);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
